// File: rtl/bcd_serial_adder_ctrl_if.sv
// Purpose: bundles the operation request/response signals and the digit-adder
//          link of bcd_serial_adder_ctrl into one interface.
// Signals: start, op_a, op_b       request and packed BCD operands (digit 0 = [3:0])
//          busy, done              status; done is a one-cycle completion pulse
//          result, cout_final      packed BCD sum and final carry
//          dig_a, dig_b, dig_cin   digit pair and carry towards the digit adder
//          dig_sum, dig_cout       digit adder response (combinational)
//          err                     invalid-digit flag, only with BCD_INVALID_CHECK_EN
// Modports: slave  = the sequencer; master = its environment (requester plus
//           the single-digit adder stage).
interface bcd_serial_adder_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout_final;
  logic [3:0]   dig_a;
  logic [3:0]   dig_b;
  logic         dig_cin;
  logic [3:0]   dig_sum;
  logic         dig_cout;
`ifdef BCD_INVALID_CHECK_EN
  logic         err;

  modport slave (
    input  start, op_a, op_b, dig_sum, dig_cout,
    output busy, done, result, cout_final, dig_a, dig_b, dig_cin, err
  );
  modport master (
    output start, op_a, op_b, dig_sum, dig_cout,
    input  busy, done, result, cout_final, dig_a, dig_b, dig_cin, err
  );
`else
  modport slave (
    input  start, op_a, op_b, dig_sum, dig_cout,
    output busy, done, result, cout_final, dig_a, dig_b, dig_cin
  );
  modport master (
    output start, op_a, op_b, dig_sum, dig_cout,
    input  busy, done, result, cout_final, dig_a, dig_b, dig_cin
  );
`endif
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Purpose: digit-serial sequencer for multi-digit packed-BCD addition. Latches
//          two DIGITS-wide operands on start and walks them LSD first, one
//          digit per clock, through an external single-digit BCD adder.
// Ports:   clk  rising-edge clock
//          rst  asynchronous, active-high reset
//          bus  bcd_serial_adder_ctrl_if.slave (request, status, result and
//               digit-adder link)
// Option:  BCD_INVALID_CHECK_EN - rejects operands containing nibbles above 9
//          (skips RUN, result 0, err set until the next accepted start).
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  bcd_serial_adder_ctrl_if.slave    bus
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Nibble k of a packed operand.
  function automatic logic [3:0] digit_of(input logic [W-1:0] v, input int unsigned k);
    logic [W-1:0] t;
    t = v >> (4 * k);
    return t[3:0];
  endfunction

`ifdef BCD_INVALID_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (digit_of(v, k) > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     op_a_q;
  logic [W-1:0]     op_b_q;
  logic [W-1:0]     shadow;
  logic [W-1:0]     merged_c;
  logic             start_bad_c;

  // Shadow is cleared on start, so each digit lands in an all-zero nibble.
  always_comb begin
    merged_c = shadow | (W'(bus.dig_sum) << (4 * 32'(idx)));
  end

  // Operand check at start; constant 0 when the check is not built in.
  always_comb begin
`ifdef BCD_INVALID_CHECK_EN
    start_bad_c = has_bad_digit(bus.op_a) | has_bad_digit(bus.op_b);
`else
    start_bad_c = 1'b0;
`endif
  end

  // Sequencer; dig_cin doubles as the running carry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      shadow         <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= '0;
      bus.cout_final <= 1'b0;
      bus.dig_a      <= 4'd0;
      bus.dig_b      <= 4'd0;
      bus.dig_cin    <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
      bus.err        <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a_q <= bus.op_a;
            op_b_q <= bus.op_b;
            idx    <= '0;
            shadow <= '0;
`ifdef BCD_INVALID_CHECK_EN
            bus.err <= start_bad_c;
`endif
            if (start_bad_c) begin
              state <= FAULT;
            end else begin
              state       <= RUN;
              bus.busy    <= 1'b1;
              bus.dig_a   <= digit_of(bus.op_a, 0);
              bus.dig_b   <= digit_of(bus.op_b, 0);
              bus.dig_cin <= 1'b0;
            end
          end
        end

        RUN: begin
          shadow <= merged_c;
          idx    <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            bus.result     <= merged_c;
            bus.cout_final <= bus.dig_cout;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            bus.dig_a      <= 4'd0;
            bus.dig_b      <= 4'd0;
            bus.dig_cin    <= 1'b0;
            state          <= DONE;
          end else begin
            bus.dig_a   <= digit_of(op_a_q, 32'(idx) + 1);
            bus.dig_b   <= digit_of(op_b_q, 32'(idx) + 1);
            bus.dig_cin <= bus.dig_cout;
          end
        end

        // Rejected operands: one idle cycle, then report an empty result.
        FAULT: begin
          bus.result     <= '0;
          bus.cout_final <= 1'b0;
          bus.done       <= 1'b1;
          state          <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
